// File: rtl/mfp_ahb_dma.sv
// mfp_ahb_dma: single-channel word-copy DMA engine with an AHB-lite master port.
// Each word is moved by one single read followed by one single write. Both are
// non-burst NONSEQ transfers. With a zero-wait slave this costs four cycles per word.
module mfp_ahb_dma #(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,

    // command / status
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,

    // AHB-lite master
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;
    localparam logic [LEN_W-1:0] LEN_ZERO      = '0;
    localparam logic [LEN_W-1:0] LEN_ONE       = LEN_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [31:0]      r_src;      // current read address (word aligned)
    logic [31:0]      r_dst;      // current write address (word aligned)
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_words;
    logic [31:0]      r_buf;      // word carried from read data phase to write data phase

    logic             w_load;     // accept a command in IDLE
    logic             w_capture;  // read data phase completed without error
    logic             w_advance;  // write data phase completed without error
    logic [31:0]      w_haddr;
    logic [1:0]       w_htrans;
    logic             w_hwrite;
    logic             w_busy;
    logic             w_done;
    logic             w_err;

    // The two low address bits are forced to zero, so those input bits carry no information.
    logic             w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    // State register; reset has priority over everything, including a same-cycle start.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and Moore-style bus/status outputs decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_haddr      = r_src;
        w_htrans     = HTRANS_IDLE;
        w_hwrite     = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_err        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_load = 1'b1;
                    if (len == LEN_ZERO) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_RD_ADDR;
                    end
                end
            end

            ST_RD_ADDR: begin
                w_htrans = HTRANS_NONSEQ;
                if (HREADY) begin
                    w_state_next = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = ST_WR_ADDR;
                    end
                end
            end

            ST_WR_ADDR: begin
                w_haddr  = r_dst;
                w_htrans = HTRANS_NONSEQ;
                w_hwrite = 1'b1;
                if (HREADY) begin
                    w_state_next = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                w_haddr  = r_dst;
                w_hwrite = 1'b1;
                if (HREADY) begin
                    if (HRESP) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_advance = 1'b1;
                        // r_remaining still counts the word being finished now
                        if (r_remaining == LEN_ONE) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_state_next = ST_RD_ADDR;
                        end
                    end
                end
            end

            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end

            ST_ERR: begin
                w_done       = 1'b1;
                w_err        = 1'b1;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: command latch, address/count advance and the read-to-write data buffer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_src       <= 32'h0;
            r_dst       <= 32'h0;
            r_remaining <= LEN_ZERO;
            r_words     <= LEN_ZERO;
            r_buf       <= 32'h0;
        end else begin
            if (w_load) begin
                r_src       <= {src_addr[31:2], 2'b00};
                r_dst       <= {dst_addr[31:2], 2'b00};
                r_remaining <= len;
                r_words     <= LEN_ZERO;
            end
            if (w_capture) begin
                r_buf <= HRDATA;
            end
            if (w_advance) begin
                // plain 32-bit adds: the address space simply wraps
                r_src       <= r_src + 32'd4;
                r_dst       <= r_dst + 32'd4;
                r_remaining <= r_remaining - LEN_ONE;
                r_words     <= r_words + LEN_ONE;
            end
        end
    end

    assign HADDR      = w_haddr;
    assign HTRANS     = w_htrans;
    assign HWRITE     = w_hwrite;
    assign HWDATA     = r_buf;
    assign HSIZE      = 3'b010;
    assign HBURST     = 3'b000;
    assign HPROT      = 4'b0011;
    assign HMASTLOCK  = 1'b0;
    assign busy       = w_busy;
    assign done       = w_done;
    assign err        = w_err;
    assign words_done = r_words;

endmodule

// File: tb/tb_mfp_ahb_dma.sv
// Directed testbench for mfp_ahb_dma with a small AHB-lite slave model:
// it has separate read and write memories, injects wait states on reads, and can
// inject an error response.
`timescale 1ns/1ps
module tb_mfp_ahb_dma;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy, done, err;
    logic [15:0] words_done;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_dma #(.LEN_W(16)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HMASTLOCK  (HMASTLOCK),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    // ---------------- slave model ----------------
    logic [31:0] rd_mem [0:255];   // preloaded source data, indexed by addr[9:2]
    logic [31:0] wr_mem [0:255];   // destination data written by the DUT
    logic [31:0] rd_log [0:15];    // read address-phase log
    logic        dp_valid = 1'b0;
    logic [31:0] dp_addr  = 32'h0;
    logic        dp_write = 1'b0;
    int          wait_cnt   = 0;
    int          rd_waits   = 0;
    int          err_at     = -1;
    int          rd_cnt     = 0;   // completed read data phases
    int          wr_cnt     = 0;   // completed write data phases
    int          nonseq_cnt = 0;
    int          wr_nonseq  = 0;
    int          rd_nonseq  = 0;
    int          done_cnt   = 0;
    int          stab_err   = 0;
    int          wait_seen  = 0;

    assign HREADY = !(dp_valid && wait_cnt != 0);
    assign HRDATA = (dp_valid && !dp_write) ? rd_mem[dp_addr[9:2]] : 32'hDEAD_BEEF;
    assign HRESP  = dp_valid && !dp_write && (wait_cnt == 0) && (rd_cnt == err_at);

    always @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            wait_cnt <= 0;
        end else begin
            if (dp_valid && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
            if (HREADY) begin
                if (dp_valid && dp_write) begin
                    wr_mem[dp_addr[9:2]] <= HWDATA;
                    wr_cnt <= wr_cnt + 1;
                end
                if (dp_valid && !dp_write) rd_cnt <= rd_cnt + 1;
                dp_valid <= (HTRANS == 2'b10);
                dp_addr  <= HADDR;
                dp_write <= HWRITE;
                wait_cnt <= (HTRANS == 2'b10 && !HWRITE) ? rd_waits : 0;
                if (HTRANS == 2'b10) begin
                    nonseq_cnt <= nonseq_cnt + 1;
                    if (HWRITE) begin
                        wr_nonseq <= wr_nonseq + 1;
                    end else begin
                        rd_log[rd_nonseq[3:0]] <= HADDR;
                        rd_nonseq <= rd_nonseq + 1;
                    end
                end
            end
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // bus stability monitor: nothing may move across an edge where HREADY was low
    logic        mon_valid  = 1'b0;
    logic        mon_hready = 1'b1;
    logic [31:0] mon_haddr, mon_hwdata;
    logic [1:0]  mon_htrans;
    always @(negedge HCLK) begin
        if (mon_valid && !mon_hready &&
            (HADDR !== mon_haddr || HTRANS !== mon_htrans || HWDATA !== mon_hwdata))
            stab_err <= stab_err + 1;
        if (!HREADY) wait_seen <= wait_seen + 1;
        mon_valid  <= 1'b1;
        mon_hready <= HREADY;
        mon_haddr  <= HADDR;
        mon_htrans <= HTRANS;
        mon_hwdata <= HWDATA;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge HCLK);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(posedge HCLK);
        #1;
        start = 1'b0;
    endtask

    // cyc = 1 is the sample right after the start edge; bounded wait
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        HRESET = 1'b1;
        start  = 1'b1;
        src_addr = 32'h8000_0100;
        dst_addr = 32'h8000_0200;
        len      = 16'd3;
        repeat (3) step();
        n_checks++;
        if ({HADDR, HTRANS, HWRITE, HWDATA} !== {32'h0, 2'b00, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_bus: HADDR=%h HTRANS=%b HWRITE=%b HWDATA=%h, required all zero", HADDR, HTRANS, HWRITE, HWDATA);
        end
        n_checks++;
        if ({busy, done, err, words_done} !== {1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b err=%b words_done=%0d, required 0/0/0/0", busy, done, err, words_done);
        end
        n_checks++;
        if ({HSIZE, HBURST, HPROT, HMASTLOCK} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_const: HSIZE=%b HBURST=%b HPROT=%b HMASTLOCK=%b, required 010/000/0011/0", HSIZE, HBURST, HPROT, HMASTLOCK);
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        start  = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: busy=%b, required 0", busy);
        end
        $display("reset: busy=%b words_done=%0d", busy, words_done);
    endtask

    task automatic test_zero_wait();
        int cyc;
        int ns0;
        ns0 = nonseq_cnt;
        start_copy(32'h8000_0100, 32'h8000_0200, 16'd3);
        wait_done(cyc);
        $display("copy zero_wait: len=3 cycles=%0d words_done=%0d err=%b", cyc, words_done, err);
        n_checks++;
        if (cyc !== 13) begin
            n_fail++;
            $display("FAIL zw_latency: done at cycle %0d, required 13", cyc);
        end
        n_checks++;
        if ({err, words_done} !== {1'b0, 16'd3}) begin
            n_fail++;
            $display("FAIL zw_status: err=%b words_done=%0d, required err=0 words_done=3", err, words_done);
        end
        step();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL zw_done_width: done=%b busy=%b one cycle later, required 0/0", done, busy);
        end
        n_checks++;
        if ({wr_mem[128], wr_mem[129], wr_mem[130]} !== {32'h1111_1111, 32'h2222_2222, 32'h3333_3333}) begin
            n_fail++;
            $display("FAIL zw_data: dst=%h %h %h, required 11111111 22222222 33333333", wr_mem[128], wr_mem[129], wr_mem[130]);
        end
        n_checks++;
        if (nonseq_cnt - ns0 !== 6) begin
            n_fail++;
            $display("FAIL zw_nonseq: %0d NONSEQ transfers, required 6", nonseq_cnt - ns0);
        end
        repeat (3) step();
        n_checks++;
        if (words_done !== 16'd3) begin
            n_fail++;
            $display("FAIL zw_hold: words_done=%0d in IDLE, required 3", words_done);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        int st0;
        int ws0;
        st0 = stab_err;
        ws0 = wait_seen;
        rd_waits = 2;
        start_copy(32'h8000_0100, 32'h8000_0240, 16'd3);
        wait_done(cyc);
        rd_waits = 0;
        $display("copy wait_states: len=3 cycles=%0d words_done=%0d err=%b", cyc, words_done, err);
        n_checks++;
        if (cyc !== 19) begin
            n_fail++;
            $display("FAIL ws_latency: done at cycle %0d, required 19", cyc);
        end
        n_checks++;
        if (wait_seen - ws0 !== 6) begin
            n_fail++;
            $display("FAIL ws_count: %0d wait cycles seen, required 6", wait_seen - ws0);
        end
        n_checks++;
        if (stab_err !== st0) begin
            n_fail++;
            $display("FAIL ws_stable: %0d bus changes during waits, required 0", stab_err - st0);
        end
        n_checks++;
        if ({wr_mem[144], wr_mem[145], wr_mem[146]} !== {32'h1111_1111, 32'h2222_2222, 32'h3333_3333}) begin
            n_fail++;
            $display("FAIL ws_data: dst=%h %h %h, required 11111111 22222222 33333333", wr_mem[144], wr_mem[145], wr_mem[146]);
        end
        step();
    endtask

    task automatic test_len_zero();
        int cyc;
        int ns0;
        ns0 = nonseq_cnt;
        start_copy(32'h8000_0100, 32'h8000_0200, 16'd0);
        wait_done(cyc);
        $display("copy len_zero: len=0 cycles=%0d words_done=%0d err=%b", cyc, words_done, err);
        n_checks++;
        if (cyc !== 1) begin
            n_fail++;
            $display("FAIL lz_latency: done at cycle %0d, required 1", cyc);
        end
        n_checks++;
        if ({err, words_done} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL lz_status: err=%b words_done=%0d, required 0/0", err, words_done);
        end
        repeat (2) step();
        n_checks++;
        if (nonseq_cnt !== ns0) begin
            n_fail++;
            $display("FAIL lz_nonseq: %0d NONSEQ transfers, required 0", nonseq_cnt - ns0);
        end
    endtask

    task automatic test_error();
        int cyc;
        int wn0;
        wn0 = wr_nonseq;
        err_at = rd_cnt + 2;
        start_copy(32'h8000_0100, 32'h8000_0280, 16'd4);
        wait_done(cyc);
        $display("copy error: len=4 cycles=%0d words_done=%0d err=%b", cyc, words_done, err);
        n_checks++;
        if (cyc !== 11) begin
            n_fail++;
            $display("FAIL er_latency: done at cycle %0d, required 11", cyc);
        end
        n_checks++;
        if ({done, err, words_done} !== {1'b1, 1'b1, 16'd2}) begin
            n_fail++;
            $display("FAIL er_status: done=%b err=%b words_done=%0d, required 1/1/2", done, err, words_done);
        end
        step();
        err_at = -1;
        n_checks++;
        if ({done, err, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL er_pulse: done=%b err=%b busy=%b next cycle, required 0/0/0", done, err, busy);
        end
        step();
        n_checks++;
        if (wr_nonseq - wn0 !== 2) begin
            n_fail++;
            $display("FAIL er_writes: %0d writes issued, required 2", wr_nonseq - wn0);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int rn0;
        int dc0;
        rn0 = rd_nonseq;
        dc0 = done_cnt;
        start_copy(32'h8000_0040, 32'h8000_0380, 16'd5);
        cyc = 1;
        // a start while busy must not reload the addresses
        src_addr = 32'h1234_0000;
        dst_addr = 32'h5678_0000;
        len      = 16'd1;
        start    = 1'b1;
        step();
        cyc++;
        start = 1'b0;
        while (cyc < 8) begin
            step();
            cyc++;
        end
        n_checks++;
        if ({HTRANS, HWRITE, busy} !== {2'b00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL rm_position: HTRANS=%b HWRITE=%b busy=%b at cycle 8, required 00/1/1 (write data phase)", HTRANS, HWRITE, busy);
        end
        HRESET   = 1'b1;
        start    = 1'b1;
        src_addr = 32'h5555_0000;
        step();
        HRESET = 1'b0;
        start  = 1'b0;
        $display("copy reset_mid_run: len=5 reset at cycle 8 busy=%b words_done=%0d", busy, words_done);
        n_checks++;
        if ({busy, HTRANS, words_done, done} !== {1'b0, 2'b00, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rm_abort: busy=%b HTRANS=%b words_done=%0d done=%b, required 0/00/0/0", busy, HTRANS, words_done, done);
        end
        repeat (4) step();
        n_checks++;
        if (done_cnt !== dc0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_no_done: %0d done pulses busy=%b, required 0 pulses busy=0", done_cnt - dc0, busy);
        end
        n_checks++;
        if (rd_log[4'(rn0 + 1)] !== 32'h8000_0044) begin
            n_fail++;
            $display("FAIL rm_start_ignored: 2nd read addr=%h, required 80000044", rd_log[4'(rn0 + 1)]);
        end
        n_checks++;
        if (wr_mem[224] !== 32'hA000_0000) begin
            n_fail++;
            $display("FAIL rm_first_word: dst=%h, required a0000000", wr_mem[224]);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        int rn0;
        rn0 = rd_nonseq;
        start_copy(32'hFFFF_FFFE, 32'h8000_0300, 16'd2);
        wait_done(cyc);
        $display("copy wrap: len=2 cycles=%0d words_done=%0d err=%b", cyc, words_done, err);
        n_checks++;
        if ({rd_log[4'(rn0)], rd_log[4'(rn0 + 1)]} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
            n_fail++;
            $display("FAIL wr_addrs: reads at %h %h, required fffffffc 00000000", rd_log[4'(rn0)], rd_log[4'(rn0 + 1)]);
        end
        n_checks++;
        if ({cyc, err, words_done} !== {32'd9, 1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL wr_status: cycle=%0d err=%b words_done=%0d, required 9/0/2", cyc, err, words_done);
        end
        step();
        n_checks++;
        if ({wr_mem[192], wr_mem[193]} !== {32'hCAFE_0001, 32'hCAFE_0002}) begin
            n_fail++;
            $display("FAIL wr_data: dst=%h %h, required cafe0001 cafe0002", wr_mem[192], wr_mem[193]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rd_mem[i] = 32'h0BAD_0000 + 32'(i);
        rd_mem[64]  = 32'h1111_1111;
        rd_mem[65]  = 32'h2222_2222;
        rd_mem[66]  = 32'h3333_3333;
        rd_mem[67]  = 32'h4444_4444;
        for (int i = 0; i < 5; i++) rd_mem[16 + i] = 32'hA000_0000 + 32'(i);
        rd_mem[255] = 32'hCAFE_0001;
        rd_mem[0]   = 32'hCAFE_0002;

        test_reset();
        test_zero_wait();
        test_wait_states();
        test_len_zero();
        test_error();
        test_reset_mid_run();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
